// File: rtl/dhcp_offer_parser_if.sv
// Byte-wide AXI-Stream link carrying the DHCP reply payload into dhcp_offer_parser.
interface dhcp_offer_parser_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/dhcp_offer_parser.sv
// Validates an inbound DHCP reply (8-bit stream from the op byte) and extracts the lease fields.
// Optional: define DHCP_CHADDR_CHECK_EN to compare chaddr bytes 28..33 against local_mac (err 7).
module dhcp_offer_parser #(
  parameter int OPT_MAX_LEN = 312
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               parse_start,
  output logic               parse_finished,
  input  logic [31:0]        expected_xid,
  input  logic [47:0]        local_mac,
  dhcp_offer_parser_if.slave s_axis,
  output logic               result_ok,
  output logic [2:0]         err_code,
  output logic [7:0]         msg_type,
  output logic [31:0]        offered_ip,
  output logic [31:0]        server_ip,
  output logic [31:0]        subnet_mask,
  output logic [31:0]        router_ip,
  output logic [31:0]        lease_time
);
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0, ST_HDR = 3'd1, ST_OPT_CODE = 3'd2, ST_OPT_LEN = 3'd3,
    ST_OPT_DATA = 3'd4, ST_DRAIN = 3'd5, ST_FIN = 3'd6, ST_DONE = 3'd7
  } state_t;

  localparam logic [2:0] ERR_NONE = 3'd0, ERR_HDR = 3'd1, ERR_XID = 3'd2, ERR_COOKIE = 3'd3;
  localparam logic [2:0] ERR_TRUNC = 3'd4, ERR_OVF = 3'd5, ERR_MSG = 3'd6, ERR_CHADDR = 3'd7;

  state_t      state_q, state_d, fwd_state_s;
  logic        tready_q, tready_d, parse_finished_q, parse_finished_d, result_ok_q, result_ok_d;
  logic [2:0]  err_q, err_d, byte_err_s, hdr_err_s;
  logic [9:0]  cnt_q, cnt_d, opt_cnt_q, opt_cnt_d;
  logic [7:0]  opt_code_q, opt_code_d, opt_len_q, opt_len_d, opt_idx_q, opt_idx_d;
  logic [7:0]  msg_stg_q, msg_stg_d, msg_type_q, msg_type_d;
  logic [31:0] yi_stg_q, yi_stg_d, srv_stg_q, srv_stg_d, mask_stg_q, mask_stg_d;
  logic [31:0] rtr_stg_q, rtr_stg_d, lease_stg_q, lease_stg_d;
  logic [31:0] offered_q, offered_d, server_q, server_d, mask_q, mask_d;
  logic [31:0] router_q, router_d, lease_q, lease_d;
  logic        xfer_s, end_opt_s, ovf_s, msg_ok_s;
  logic [7:0]  xid_byte_s, cookie_byte_s, din_s;

  assign din_s    = s_axis.tdata;
  assign xfer_s   = s_axis.tvalid && tready_q;
  assign ovf_s    = ({22'd0, opt_cnt_q} + 32'd1) > 32'(OPT_MAX_LEN);
  assign msg_ok_s = (msg_stg_q == 8'd2) || (msg_stg_q == 8'd5) || (msg_stg_q == 8'd6);

  // Per-offset header checks: expected xid and cookie bytes, MSB first.
  always_comb begin
    case (cnt_q[1:0])
      2'd0:    begin xid_byte_s = expected_xid[31:24]; cookie_byte_s = 8'h63; end
      2'd1:    begin xid_byte_s = expected_xid[23:16]; cookie_byte_s = 8'h82; end
      2'd2:    begin xid_byte_s = expected_xid[15:8];  cookie_byte_s = 8'h53; end
      default: begin xid_byte_s = expected_xid[7:0];   cookie_byte_s = 8'h63; end
    endcase
    case (cnt_q)
      10'd0:   hdr_err_s = (din_s == 8'h02) ? ERR_NONE : ERR_HDR;
      10'd1:   hdr_err_s = (din_s == 8'h01) ? ERR_NONE : ERR_HDR;
      10'd2:   hdr_err_s = (din_s == 8'h06) ? ERR_NONE : ERR_HDR;
      10'd4, 10'd5, 10'd6, 10'd7:
               hdr_err_s = (din_s == xid_byte_s) ? ERR_NONE : ERR_XID;
`ifdef DHCP_CHADDR_CHECK_EN
      10'd28:  hdr_err_s = (din_s == local_mac[47:40]) ? ERR_NONE : ERR_CHADDR;
      10'd29:  hdr_err_s = (din_s == local_mac[39:32]) ? ERR_NONE : ERR_CHADDR;
      10'd30:  hdr_err_s = (din_s == local_mac[31:24]) ? ERR_NONE : ERR_CHADDR;
      10'd31:  hdr_err_s = (din_s == local_mac[23:16]) ? ERR_NONE : ERR_CHADDR;
      10'd32:  hdr_err_s = (din_s == local_mac[15:8])  ? ERR_NONE : ERR_CHADDR;
      10'd33:  hdr_err_s = (din_s == local_mac[7:0])   ? ERR_NONE : ERR_CHADDR;
`endif
      10'd236, 10'd237, 10'd238, 10'd239:
               hdr_err_s = (din_s == cookie_byte_s) ? ERR_NONE : ERR_COOKIE;
      default: hdr_err_s = ERR_NONE;
    endcase
  end

`ifndef DHCP_CHADDR_CHECK_EN
  logic unused_mac_s;
  assign unused_mac_s = ^local_mac;
`endif

  // Byte decode: counters, option walker and staging registers.
  always_comb begin
    byte_err_s = ERR_NONE;   fwd_state_s = state_q;   end_opt_s = 1'b0;
    cnt_d = cnt_q;           opt_cnt_d = opt_cnt_q;   opt_code_d = opt_code_q;
    opt_len_d = opt_len_q;   opt_idx_d = opt_idx_q;   msg_stg_d = msg_stg_q;
    yi_stg_d = yi_stg_q;     srv_stg_d = srv_stg_q;   mask_stg_d = mask_stg_q;
    rtr_stg_d = rtr_stg_q;   lease_stg_d = lease_stg_q;
    case (state_q)
      ST_IDLE: begin
        if (parse_start) begin
          cnt_d = 10'd0;     opt_cnt_d = 10'd0;   opt_code_d = 8'd0;  opt_len_d = 8'd0;
          opt_idx_d = 8'd0;  msg_stg_d = 8'd0;    yi_stg_d = 32'd0;   srv_stg_d = 32'd0;
          mask_stg_d = 32'd0; rtr_stg_d = 32'd0;  lease_stg_d = 32'd0;
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_HDR: begin
        if (xfer_s) begin
          byte_err_s  = hdr_err_s;
          cnt_d       = cnt_q + 10'd1;
          yi_stg_d    = (cnt_q >= 10'd16 && cnt_q <= 10'd19) ? {yi_stg_q[23:0], din_s} : yi_stg_q;
          fwd_state_s = (cnt_q == 10'd239) ? ST_OPT_CODE : ST_HDR;
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_OPT_CODE: begin
        if (xfer_s) begin
          opt_cnt_d  = opt_cnt_q + 10'd1;
          opt_code_d = din_s;
          end_opt_s  = (din_s == 8'hFF);
          byte_err_s = (ovf_s && !end_opt_s) ? ERR_OVF : ERR_NONE;
          if (end_opt_s) begin
            fwd_state_s = ST_DRAIN;
          end else begin
            fwd_state_s = (din_s == 8'h00) ? ST_OPT_CODE : ST_OPT_LEN;
          end
        end else begin
          opt_cnt_d = opt_cnt_q;
        end
      end
      ST_OPT_LEN: begin
        if (xfer_s) begin
          opt_cnt_d   = opt_cnt_q + 10'd1;
          opt_len_d   = din_s;
          opt_idx_d   = 8'd0;
          byte_err_s  = ovf_s ? ERR_OVF : ERR_NONE;
          fwd_state_s = (din_s == 8'h00) ? ST_OPT_CODE : ST_OPT_DATA;
        end else begin
          opt_cnt_d = opt_cnt_q;
        end
      end
      ST_OPT_DATA: begin
        if (xfer_s) begin
          opt_cnt_d   = opt_cnt_q + 10'd1;
          opt_idx_d   = opt_idx_q + 8'd1;
          byte_err_s  = ovf_s ? ERR_OVF : ERR_NONE;
          fwd_state_s = (opt_idx_q == opt_len_q - 8'd1) ? ST_OPT_CODE : ST_OPT_DATA;
          // Only well-formed lengths are captured; router keeps the first address of its list.
          case (opt_code_q)
            8'd53:   msg_stg_d   = (opt_len_q == 8'd1) ? din_s : msg_stg_q;
            8'd1:    mask_stg_d  = (opt_len_q == 8'd4) ? {mask_stg_q[23:0], din_s} : mask_stg_q;
            8'd51:   lease_stg_d = (opt_len_q == 8'd4) ? {lease_stg_q[23:0], din_s} : lease_stg_q;
            8'd54:   srv_stg_d   = (opt_len_q == 8'd4) ? {srv_stg_q[23:0], din_s} : srv_stg_q;
            8'd3:    rtr_stg_d   = (opt_len_q >= 8'd4 && opt_idx_q < 8'd4) ?
                                   {rtr_stg_q[23:0], din_s} : rtr_stg_q;
            default: msg_stg_d   = msg_stg_q;
          endcase
        end else begin
          opt_cnt_d = opt_cnt_q;
        end
      end
      default: cnt_d = cnt_q;
    endcase
  end

  // Control FSM next state and registered outputs.
  always_comb begin
    state_d = state_q;           err_d = err_q;             result_ok_d = result_ok_q;
    parse_finished_d = parse_finished_q;                     msg_type_d = msg_type_q;
    offered_d = offered_q;       server_d = server_q;       mask_d = mask_q;
    router_d = router_q;         lease_d = lease_q;
    case (state_q)
      ST_IDLE: begin
        if (parse_start) begin
          err_d       = ERR_NONE;
          result_ok_d = 1'b0;
          state_d     = ST_HDR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HDR, ST_OPT_CODE, ST_OPT_LEN, ST_OPT_DATA: begin
        if (!xfer_s) begin
          state_d = state_q;
        end else if (byte_err_s != ERR_NONE) begin
          err_d   = byte_err_s;
          state_d = s_axis.tlast ? ST_FIN : ST_DRAIN;
        end else if (s_axis.tlast) begin
          err_d   = end_opt_s ? ERR_NONE : ERR_TRUNC;
          state_d = ST_FIN;
        end else begin
          state_d = fwd_state_s;
        end
      end
      ST_DRAIN: begin
        state_d = (xfer_s && s_axis.tlast) ? ST_FIN : ST_DRAIN;
      end
      ST_FIN: begin
        parse_finished_d = 1'b1;
        state_d          = ST_DONE;
        if (err_q == ERR_NONE && msg_ok_s) begin
          result_ok_d = 1'b1;       msg_type_d = msg_stg_q;   offered_d = yi_stg_q;
          server_d = srv_stg_q;     mask_d = mask_stg_q;      router_d = rtr_stg_q;
          lease_d = lease_stg_q;
        end else begin
          result_ok_d = 1'b0;
          err_d       = (err_q == ERR_NONE) ? ERR_MSG : err_q;
        end
      end
      ST_DONE: begin
        if (!parse_start) begin
          parse_finished_d = 1'b0;
          state_d          = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    tready_d = (state_d == ST_HDR) || (state_d == ST_OPT_CODE) || (state_d == ST_OPT_LEN) ||
               (state_d == ST_OPT_DATA) || (state_d == ST_DRAIN);
  end

  // State, staging and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;     tready_q <= 1'b0;     parse_finished_q <= 1'b0;  result_ok_q <= 1'b0;
      err_q <= ERR_NONE;      cnt_q <= 10'd0;       opt_cnt_q <= 10'd0;        opt_code_q <= 8'd0;
      opt_len_q <= 8'd0;      opt_idx_q <= 8'd0;    msg_stg_q <= 8'd0;         msg_type_q <= 8'd0;
      yi_stg_q <= 32'd0;      srv_stg_q <= 32'd0;   mask_stg_q <= 32'd0;       rtr_stg_q <= 32'd0;
      lease_stg_q <= 32'd0;   offered_q <= 32'd0;   server_q <= 32'd0;         mask_q <= 32'd0;
      router_q <= 32'd0;      lease_q <= 32'd0;
    end else begin
      state_q <= state_d;     tready_q <= tready_d; parse_finished_q <= parse_finished_d;
      result_ok_q <= result_ok_d;                   err_q <= err_d;
      cnt_q <= cnt_d;         opt_cnt_q <= opt_cnt_d; opt_code_q <= opt_code_d;
      opt_len_q <= opt_len_d; opt_idx_q <= opt_idx_d; msg_stg_q <= msg_stg_d;  msg_type_q <= msg_type_d;
      yi_stg_q <= yi_stg_d;   srv_stg_q <= srv_stg_d; mask_stg_q <= mask_stg_d; rtr_stg_q <= rtr_stg_d;
      lease_stg_q <= lease_stg_d; offered_q <= offered_d; server_q <= server_d; mask_q <= mask_d;
      router_q <= router_d;   lease_q <= lease_d;
    end
  end

  assign s_axis.tready  = tready_q;
  assign parse_finished = parse_finished_q;
  assign result_ok      = result_ok_q;
  assign err_code       = err_q;
  assign msg_type       = msg_type_q;
  assign offered_ip     = offered_q;
  assign server_ip      = server_q;
  assign subnet_mask    = mask_q;
  assign router_ip      = router_q;
  assign lease_time     = lease_q;
endmodule

// File: tb/tb_dhcp_offer_parser.sv
// Directed bench for dhcp_offer_parser: hand-built DHCP replies with hand-computed expectations.
module tb_dhcp_offer_parser;
  logic        clk = 1'b0;
  logic        rst;
  logic        parse_start;
  logic        parse_finished;
  logic [31:0] expected_xid;
  logic [47:0] local_mac;
  logic        result_ok;
  logic [2:0]  err_code;
  logic [7:0]  msg_type;
  logic [31:0] offered_ip, server_ip, subnet_mask, router_ip, lease_time;

  int          n_cmp = 0;
  int          n_mis = 0;
  logic [7:0]  fr [0:1023];
  int          fr_len;

  dhcp_offer_parser_if bus();

  dhcp_offer_parser dut (
    .clk(clk), .rst(rst), .parse_start(parse_start), .parse_finished(parse_finished),
    .expected_xid(expected_xid), .local_mac(local_mac), .s_axis(bus),
    .result_ok(result_ok), .err_code(err_code), .msg_type(msg_type),
    .offered_ip(offered_ip), .server_ip(server_ip), .subnet_mask(subnet_mask),
    .router_ip(router_ip), .lease_time(lease_time)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic put(input logic [7:0] b);
    fr[fr_len] = b;
    fr_len++;
  endtask

  task automatic put_opt4(input logic [7:0] code, input logic [31:0] v);
    put(code); put(8'd4); put(v[31:24]); put(v[23:16]); put(v[15:8]); put(v[7:0]);
  endtask

  task automatic build_hdr(input logic [31:0] xid, input logic [31:0] yi);
    fr_len = 0;
    for (int i = 0; i < 240; i++) put(8'h00);
    fr[0] = 8'h02; fr[1] = 8'h01; fr[2] = 8'h06;
    fr[4] = xid[31:24]; fr[5] = xid[23:16]; fr[6] = xid[15:8]; fr[7] = xid[7:0];
    fr[16] = yi[31:24]; fr[17] = yi[23:16]; fr[18] = yi[15:8]; fr[19] = yi[7:0];
    for (int i = 0; i < 6; i++) fr[28 + i] = local_mac[47 - 8*i -: 8];
    fr[236] = 8'h63; fr[237] = 8'h82; fr[238] = 8'h53; fr[239] = 8'h63;
  endtask

  task automatic put_std_opts(input logic [7:0] msg);
    put(8'd53); put(8'd1); put(msg);
    put_opt4(8'd54, 32'hC0A80201);
    put_opt4(8'd1,  32'hFFFFFF00);
    put_opt4(8'd3,  32'hC0A80201);
    put_opt4(8'd51, 32'h00015180);
    put(8'hFF);
    for (int i = 0; i < 4; i++) put(8'h00);
  endtask

  // Streams fr[0..fr_len-1]; returns right after the edge that accepts the last byte.
  task automatic send_frame(input bit toggle, input int rst_at, output bit ok);
    int i = 0;
    int cyc = 0;
    bit ph = 1'b0;
    ok = 1'b1;
    parse_start = 1'b1;
    while (i < fr_len && ok) begin
      @(negedge clk);
      cyc++;
      if (cyc > 4000) begin
        ok = 1'b0;
      end else if (i == rst_at) begin
        bus.tvalid = 1'b0; bus.tlast = 1'b0; parse_start = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        return;
      end else if (toggle && ph) begin
        bus.tvalid = 1'b0;
        ph = 1'b0;
      end else begin
        bus.tvalid = 1'b1;
        bus.tdata  = fr[i];
        bus.tlast  = (i == fr_len - 1);
        ph = 1'b1;
        if (bus.tready) i++;
      end
    end
    @(posedge clk);
    #1;
    bus.tvalid = 1'b0;
    bus.tlast  = 1'b0;
  endtask

  task automatic run_frame(input string tag, input bit toggle, input bit exp_ok, input logic [2:0] exp_err);
    bit ok;
    send_frame(toggle, -1, ok);
    check_eq({tag, "_accepted"}, 32'(ok), 32'd1);
    @(negedge clk);
    check_eq({tag, "_pf_lat0"}, 32'(parse_finished), 32'd0);
    @(negedge clk);
    check_eq({tag, "_pf_lat1"}, 32'(parse_finished), 32'd1);
    check_eq({tag, "_ok"}, 32'(result_ok), 32'(exp_ok));
    check_eq({tag, "_err"}, 32'(err_code), 32'(exp_err));
    parse_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq({tag, "_pf_clr"}, 32'(parse_finished), 32'd0);
    check_eq({tag, "_err_hold"}, 32'(err_code), 32'(exp_err));
  endtask

  initial begin
    bit ok;
    rst = 1'b1; parse_start = 1'b0;
    expected_xid = 32'h12345678; local_mac = 48'h02AABBCCDDEE;
    bus.tdata = 8'h00; bus.tvalid = 1'b0; bus.tlast = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_pf", 32'(parse_finished), 32'd0);
    check_eq("rst_ok", 32'(result_ok), 32'd0);
    check_eq("rst_err", 32'(err_code), 32'd0);
    check_eq("rst_ip", offered_ip, 32'd0);
    check_eq("rst_tready", 32'(bus.tready), 32'd0);

    // Valid OFFER
    build_hdr(32'h12345678, 32'hC0A8024D); put_std_opts(8'd2);
    run_frame("offer", 1'b0, 1'b1, 3'd0);
    check_eq("offer_msg", 32'(msg_type), 32'd2);
    check_eq("offer_ip", offered_ip, 32'hC0A8024D);
    check_eq("offer_srv", server_ip, 32'hC0A80201);
    check_eq("offer_mask", subnet_mask, 32'hFFFFFF00);
    check_eq("offer_rtr", router_ip, 32'hC0A80201);
    check_eq("offer_lease", lease_time, 32'h00015180);

    // Wrong xid: drained, values untouched
    build_hdr(32'h12345679, 32'h0A000009); put_std_opts(8'd2);
    run_frame("xid", 1'b0, 1'b0, 3'd2);
    check_eq("xid_ip_hold", offered_ip, 32'hC0A8024D);

    build_hdr(32'h12345678, 32'h0A000009); fr[238] = 8'h54; put_std_opts(8'd2);
    run_frame("cookie", 1'b0, 1'b0, 3'd3);
    build_hdr(32'h12345678, 32'h0A000009); fr[0] = 8'h01; put_std_opts(8'd2);
    run_frame("op", 1'b0, 1'b0, 3'd1);

    build_hdr(32'h12345678, 32'h0A000009); fr_len = 101;
    run_frame("trunc_hdr", 1'b0, 1'b0, 3'd4);
    build_hdr(32'h12345678, 32'h0A000009);
    put(8'd53); put(8'd1); put(8'd2); put(8'd51); put(8'd4); put(8'h00); put(8'h01);
    run_frame("trunc_opt", 1'b0, 1'b0, 3'd4);

    // Option-region size boundary around 312 bytes
    build_hdr(32'h12345678, 32'h0A000009); for (int i = 0; i < 312; i++) put(8'h00);
    run_frame("pad312", 1'b0, 1'b0, 3'd4);
    build_hdr(32'h12345678, 32'h0A000009); for (int i = 0; i < 313; i++) put(8'h00);
    run_frame("pad313", 1'b0, 1'b0, 3'd5);
    build_hdr(32'h12345678, 32'h0A000009); for (int i = 0; i < 320; i++) put(8'h00);
    run_frame("pad320", 1'b0, 1'b0, 3'd5);
    check_eq("pad320_ip_hold", offered_ip, 32'hC0A8024D);

    // ACK with leading pad and an 8-byte router list
    build_hdr(32'h12345678, 32'hC0A80A32);
    put(8'h00); put(8'd53); put(8'd1); put(8'd5);
    put_opt4(8'd54, 32'hC0A80A01); put_opt4(8'd1, 32'hFFFF0000);
    put(8'd3); put(8'd8); put(8'hC0); put(8'hA8); put(8'h0A); put(8'h01);
    put(8'hC0); put(8'hA8); put(8'h0A); put(8'h02);
    put_opt4(8'd51, 32'h00000E10); put(8'hFF);
    run_frame("ack", 1'b0, 1'b1, 3'd0);
    check_eq("ack_msg", 32'(msg_type), 32'd5);
    check_eq("ack_ip", offered_ip, 32'hC0A80A32);
    check_eq("ack_srv", server_ip, 32'hC0A80A01);
    check_eq("ack_mask", subnet_mask, 32'hFFFF0000);
    check_eq("ack_rtr", router_ip, 32'hC0A80A01);
    check_eq("ack_lease", lease_time, 32'h00000E10);

    // No option 53
    build_hdr(32'h12345678, 32'h0A000009); put_opt4(8'd54, 32'h01020304); put(8'hFF);
    run_frame("nomsg", 1'b0, 1'b0, 3'd6);
    check_eq("nomsg_srv_hold", server_ip, 32'hC0A80A01);

    // Reset mid-frame with gappy tvalid
    build_hdr(32'h12345678, 32'hC0A8024E); put_std_opts(8'd2);
    send_frame(1'b1, 50, ok);
    check_eq("mrst_tready", 32'(bus.tready), 32'd0);
    check_eq("mrst_pf", 32'(parse_finished), 32'd0);
    check_eq("mrst_ok", 32'(result_ok), 32'd0);
    check_eq("mrst_ip", offered_ip, 32'd0);
    check_eq("mrst_rtr", router_ip, 32'd0);
    repeat (3) @(negedge clk);
    check_eq("mrst_idle_tready", 32'(bus.tready), 32'd0);
    run_frame("clean", 1'b1, 1'b1, 3'd0);
    check_eq("clean_ip", offered_ip, 32'hC0A8024E);
    check_eq("clean_lease", lease_time, 32'h00015180);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
